serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell reused over WIDTH cycles, LSB first.
// Start is sampled only in IDLE; results and handshake outputs are all registered.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0]) | ((a_q[0] | b_q[0]) & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {fa_s, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the shifted-in value, not the stale register.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 4, 2 and 32 in parallel, each against a
// timeline model of when results must appear and what A+B+cin must be.
module tb_serial_adder;
  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] s;
    logic        co;
  } vec_t;

  localparam int NLIT = 13;

  function automatic vec_t lit(input int i);
    vec_t v;
    case (i)
      0:  v = '{8,  32'h00,       32'h00,       1'b0, 32'h00,       1'b0};
      1:  v = '{8,  32'hFF,       32'h01,       1'b0, 32'h00,       1'b1};
      2:  v = '{8,  32'hA5,       32'h5A,       1'b1, 32'h00,       1'b1};
      3:  v = '{8,  32'h3C,       32'h0F,       1'b0, 32'h4B,       1'b0};
      4:  v = '{8,  32'hFF,       32'hFF,       1'b1, 32'hFF,       1'b1};
      5:  v = '{4,  32'hF,        32'h1,        1'b0, 32'h0,        1'b1};
      6:  v = '{4,  32'h7,        32'h8,        1'b1, 32'h0,        1'b1};
      7:  v = '{4,  32'h5,        32'h6,        1'b0, 32'hB,        1'b0};
      8:  v = '{2,  32'h3,        32'h3,        1'b1, 32'h3,        1'b1};
      9:  v = '{2,  32'h1,        32'h2,        1'b0, 32'h3,        1'b0};
      10: v = '{32, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
      11: v = '{32, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
      12: v = '{32, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1};
      default: v = '{0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gen_w
    localparam int W = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 2 : 32;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    bit           fin   = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a_in (a_in),
      .b_in (b_in),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
    );

    // Model: n counts edges since reset, e0 is the edge a start was accepted.
    longint       n      = 0;
    longint       e0     = 0;
    bit           act    = 1'b0;
    logic [W:0]   pend   = '0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        act = 1'b0; m_sum = '0; m_cout = 1'b0; n = 0;
      end else begin
        n++;
        if (act && n == e0 + W) {m_cout, m_sum} = pend;
        if (start && (!act || n >= e0 + W + 2)) begin
          e0   = n;
          act  = 1'b1;
          pend = {1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin);
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("w%0d_busy e%0d", W, n), 64'(busy), 64'(act && n >= e0 && n < e0 + W));
      chk($sformatf("w%0d_done e%0d", W, n), 64'(done), 64'(act && n == e0 + W));
      chk($sformatf("w%0d_sum e%0d", W, n),  64'(sum),  64'(m_sum));
      chk($sformatf("w%0d_cout e%0d", W, n), 64'(cout), 64'(m_cout));
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co);
      int k;
      @(negedge clk); #1;
      a_in = a; b_in = b; cin = c; start = 1'b1;
      @(negedge clk); k = 1;
      #1 start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
      while (done !== 1'b1 && k < W + 5) begin
        @(negedge clk); k++;
      end
      chk($sformatf("w%0d_latency", W), 64'(k), 64'(W + 1));
      s  = sum;
      co = cout;
    endtask

    initial begin
      logic [W-1:0] s;
      logic         co;
      vec_t         v;
      int           dn, nex, rw;
      repeat (3) @(negedge clk);
      chk($sformatf("w%0d_rst_busy", W), 64'(busy), 64'(0));
      chk($sformatf("w%0d_rst_done", W), 64'(done), 64'(0));
      chk($sformatf("w%0d_rst_sum", W),  64'(sum),  64'(0));
      chk($sformatf("w%0d_rst_cout", W), 64'(cout), 64'(0));
      #1 rst_n = 1'b1;

      for (int i = 0; i < NLIT; i++) begin
        v = lit(i);
        if (v.w == W) begin
          run_op(W'(v.a), W'(v.b), v.c, s, co);
          chk($sformatf("w%0d_lit%0d_sum", W, i),  64'(s),  64'(v.s));
          chk($sformatf("w%0d_lit%0d_cout", W, i), 64'(co), 64'(v.co));
        end
      end

      nex = (W <= 4) ? (1 << (2 * W + 1)) : 0;
      for (int x = 0; x < nex; x++) run_op(W'(x), W'(x >> W), x[2*W], s, co);
      for (int r = 0; r < 1000; r++) run_op(W'($urandom), W'($urandom), 1'($urandom), s, co);

      // start held high with operands changing every cycle
      @(negedge clk); #1;
      start = 1'b1; a_in = W'($urandom); b_in = W'($urandom); cin = 1'b1;
      dn = 0;
      repeat (3 * (W + 2)) begin
        @(negedge clk);
        if (done) dn++;
        #1 a_in = W'($urandom); b_in = W'($urandom);
      end
      start = 1'b0;
      chk($sformatf("w%0d_hs_dones", W), 64'(dn), 64'(3));
      repeat (2) @(negedge clk);

      // abort mid-run with a nonzero result held beforehand
      run_op(W'(1), W'(0), 1'b0, s, co);
      chk($sformatf("w%0d_pre_sum", W), 64'(s), 64'(1));
      rw = (W > 4) ? 3 : W - 1;
      @(negedge clk); #1 start = 1'b1; a_in = '1; b_in = '1;
      @(negedge clk); #1 start = 1'b0;
      repeat (rw) @(negedge clk);
      chk($sformatf("w%0d_pre_busy", W), 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk($sformatf("w%0d_abort_busy", W), 64'(busy), 64'(0));
      chk($sformatf("w%0d_abort_done", W), 64'(done), 64'(0));
      chk($sformatf("w%0d_abort_sum", W),  64'(sum),  64'(0));
      chk($sformatf("w%0d_abort_cout", W), 64'(cout), 64'(0));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      dn = 0;
      repeat (W + 4) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk($sformatf("w%0d_abort_nodone", W), 64'(dn), 64'(0));

      run_op('1, '0, 1'b1, s, co);
      chk($sformatf("w%0d_post_sum", W),  64'(s),  64'(0));
      chk($sformatf("w%0d_post_cout", W), 64'(co), 64'(1));
      repeat (2) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(gen_w[0].fin && gen_w[1].fin && gen_w[2].fin && gen_w[3].fin) && t < 80000) begin
      @(posedge clk);
      t++;
    end
    chk("all_instances_finished", 64'(t < 80000), 64'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
